// File: rtl/mac_execute.sv
// mac_execute: pipelined fixed-point multiply-accumulate unit that writes STORE results back to a register file.
// Optional round-half-up on STORE when the macro MAC_EXECUTE_ROUND_EN is defined; truncation otherwise.
module mac_execute #(
  parameter int unsigned REGADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FRAC_BITS     = 31,
  parameter int unsigned GUARD_BITS    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            opValid,
  input  logic [2:0]                      op,
  input  logic [REGADDR_WIDTH-1:0]        destAddr,
  input  logic signed [DATA_WIDTH-1:0]    dataA,
  input  logic signed [DATA_WIDTH-1:0]    dataB,
  output logic [REGADDR_WIDTH-1:0]        writeAddr,
  output logic [DATA_WIDTH-1:0]           dataW,
  output logic                            writeEnable,
  output logic                            satFlag,
  input  logic                            clrSat
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;
  localparam int unsigned RND_WIDTH  = ACC_WIDTH + 1;

  localparam logic [2:0] OP_CLR   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_MAC   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  logic                           v1, v2;
  logic [2:0]                     op1, op2;
  logic [REGADDR_WIDTH-1:0]       dest1, dest2;
  logic signed [PROD_WIDTH-1:0]   prod;
  logic signed [DATA_WIDTH-1:0]   add_a;
  logic signed [ACC_WIDTH-1:0]    acc;

  logic signed [ACC_WIDTH-1:0]    acc_next_c;
  logic signed [RND_WIDTH-1:0]    rnd_c;
  logic signed [RND_WIDTH-1:0]    shift_c;
  logic                           pos_ovf_c, neg_ovf_c, store_c, sat_c;
  logic [DATA_WIDTH-1:0]          result_c;

  // Stage 1 aligns the op with its operands; stage 2 holds the product and ADD operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      op1   <= '0;
      dest1 <= '0;
      v2    <= 1'b0;
      op2   <= '0;
      dest2 <= '0;
      prod  <= '0;
      add_a <= '0;
      acc   <= '0;
    end else begin
      v1    <= opValid;
      op1   <= op;
      dest1 <= destAddr;
      v2    <= v1;
      op2   <= op1;
      dest2 <= dest1;
      prod  <= PROD_WIDTH'(dataA) * PROD_WIDTH'(dataB);
      add_a <= dataA;
      acc   <= acc_next_c;
    end
  end

  always_comb begin
    acc_next_c = acc;
    if (v2) begin
      case (op2)
        OP_CLR:  acc_next_c = '0;
        OP_MUL:  acc_next_c = ACC_WIDTH'(prod);
        OP_MAC:  acc_next_c = acc + ACC_WIDTH'(prod);
        OP_ADD:  acc_next_c = acc + (ACC_WIDTH'(add_a) <<< FRAC_BITS);
        default: acc_next_c = acc;
      endcase
    end
  end

  // STORE reads the committed acc, which already holds the previous op's update.
  always_comb begin
    rnd_c = RND_WIDTH'(acc);
`ifdef MAC_EXECUTE_ROUND_EN
    rnd_c = rnd_c + (RND_WIDTH'(1) << (FRAC_BITS - 1));
`endif
    shift_c   = rnd_c >>> FRAC_BITS;
    pos_ovf_c = !shift_c[RND_WIDTH-1] && (|shift_c[RND_WIDTH-2:DATA_WIDTH-1]);
    neg_ovf_c = shift_c[RND_WIDTH-1] && !(&shift_c[RND_WIDTH-2:DATA_WIDTH-1]);
    result_c  = shift_c[DATA_WIDTH-1:0];
    if (pos_ovf_c) result_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (neg_ovf_c) result_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    store_c = v2 && (op2 == OP_STORE);
    sat_c   = store_c && (pos_ovf_c || neg_ovf_c);
  end

  // Write port pulses one cycle per STORE; register 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      dataW       <= '0;
      satFlag     <= 1'b0;
    end else begin
      writeEnable <= 1'b0;
      if (store_c && (dest2 != '0)) begin
        writeEnable <= 1'b1;
        writeAddr   <= dest2;
        dataW       <= result_c;
      end
      if (sat_c) satFlag <= 1'b1;
      else if (clrSat) satFlag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_execute.sv
// tb_mac_execute: directed stimulus for mac_execute with an arithmetic reference model and per-cycle compare.
// Honours MAC_EXECUTE_ROUND_EN the same way as the design.
module tb_mac_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        opValid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [4:0]  destAddr = 5'd0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic [4:0]  writeAddr;
  logic [31:0] dataW;
  logic        writeEnable;
  logic        satFlag;
  logic        clrSat = 1'b0;

  mac_execute dut (
    .clk(clk), .rst_n(rst_n), .opValid(opValid), .op(op), .destAddr(destAddr),
    .dataA(dataA), .dataB(dataB), .writeAddr(writeAddr), .dataW(dataW),
    .writeEnable(writeEnable), .satFlag(satFlag), .clrSat(clrSat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: accumulator plus per-cycle expected outputs.
  logic signed [71:0] acc_m = '0;
  logic [31:0]        last_res = '0;
  bit                 exp_we   [0:1023];
  logic [4:0]         exp_addr [0:1023];
  logic [31:0]        exp_data [0:1023];
  bit                 sat_set  [0:1023];
  bit                 sat_clr  [0:1023];
  bit                 sat_m = 1'b0;
  logic [31:0]        pa = '0, pb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic signed [71:0] sprod(input logic [31:0] a, input logic [31:0] b);
    logic signed [71:0] x, y;
    x = 72'($signed(a));
    y = 72'($signed(b));
    return x * y;
  endfunction

  task automatic model_store(output logic [31:0] res, output bit sat);
    logic signed [72:0] v;
    v = 73'(acc_m);
`ifdef MAC_EXECUTE_ROUND_EN
    v = v + 73'sd1073741824;
`endif
    v = v >>> 31;
    sat = 1'b1;
    if (v > 73'sd2147483647) res = 32'h7FFFFFFF;
    else if (v < -73'sd2147483648) res = 32'h80000000;
    else begin
      res = v[31:0];
      sat = 1'b0;
    end
  endtask

  task automatic model_issue(input logic [2:0] o, input logic [4:0] d,
                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit s;
    case (o)
      3'd1: acc_m = '0;
      3'd2: acc_m = sprod(a, b);
      3'd3: acc_m = acc_m + sprod(a, b);
      3'd4: acc_m = acc_m + 72'($signed(a)) * 72'sd2147483648;
      3'd5: begin
        model_store(r, s);
        last_res = r;
        if (s) sat_set[cyc+3] = 1'b1;
        if (d != 5'd0) begin
          exp_we[cyc+3]   = 1'b1;
          exp_addr[cyc+3] = d;
          exp_data[cyc+3] = r;
        end
      end
      default: ;
    endcase
  endtask

  // Drive one issue slot; operands for the previous slot's op go out alongside.
  task automatic step(input bit v, input logic [2:0] o, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] b, input bit clr);
    opValid = v; op = o; destAddr = d; clrSat = clr;
    dataA = pa; dataB = pb;
    pa = a; pb = b;
    if (clr) sat_clr[cyc+1] = 1'b1;
    if (v) model_issue(o, d, a, b);
    @(negedge clk);
  endtask

  task automatic nop();
    step(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic iss(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, o, 5'd0, a, b, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; opValid = 1'b0; clrSat = 1'b0;
    dataA = '0; dataB = '0; pa = '0; pb = '0;
    acc_m = '0;
    for (int i = cyc + 1; i < 1024; i++) begin
      exp_we[i] = 1'b0; sat_set[i] = 1'b0; sat_clr[i] = 1'b0;
    end
    @(negedge clk);
    chk("rst_we", 32'(writeEnable), 32'd0);
    chk("rst_addr", 32'(writeAddr), 32'd0);
    chk("rst_data", dataW, 32'd0);
    chk("rst_sat", 32'(satFlag), 32'd0);
    rst_n = 1'b1;
  endtask

  // STORE then inspect the write port directly three cycles later.
  task automatic store_lit(input string name, input logic [4:0] d,
                           input logic [31:0] exp, input bit exp_sat);
    step(1'b1, 3'd5, d, 32'd0, 32'd0, 1'b0);
    chk({name, "_model"}, last_res, exp);
    nop();
    nop();
    chk({name, "_we"}, 32'(writeEnable), 32'(d != 5'd0));
    if (d != 5'd0) begin
      chk({name, "_addr"}, 32'(writeAddr), 32'(d));
      chk({name, "_data"}, dataW, exp);
    end
    chk({name, "_sat"}, 32'(satFlag), 32'(exp_sat));
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) sat_m = 1'b0;
    else if (sat_set[cyc]) sat_m = 1'b1;
    else if (sat_clr[cyc]) sat_m = 1'b0;
    chk("cyc_we", 32'(writeEnable), 32'(exp_we[cyc]));
    if (exp_we[cyc]) begin
      chk("cyc_addr", 32'(writeAddr), 32'(exp_addr[cyc]));
      chk("cyc_data", dataW, exp_data[cyc]);
    end
    chk("cyc_sat", 32'(satFlag), 32'(sat_m));
  end

  initial begin
    @(negedge clk);
    do_reset();
    // First op right at reset release.
    iss(3'd2, 32'h40000000, 32'h40000000);
    store_lit("mul_half", 5'd3, 32'h20000000, 1'b0);

    iss(3'd1, 32'd0, 32'd0);
    iss(3'd3, 32'h7FFFFFFF, 32'h7FFFFFFF);
    iss(3'd3, 32'h7FFFFFFF, 32'h7FFFFFFF);
    store_lit("mac_sat", 5'd5, 32'h7FFFFFFF, 1'b1);
    step(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("clr_sat", 32'(satFlag), 32'd0);

    iss(3'd2, 32'h80000000, 32'h7FFFFFFF);
    store_lit("mul_neg", 5'd7, 32'h80000001, 1'b0);

    iss(3'd2, 32'h00000001, 32'h40000000);
`ifdef MAC_EXECUTE_ROUND_EN
    store_lit("tiny", 5'd2, 32'h00000001, 1'b0);
`else
    store_lit("tiny", 5'd2, 32'h00000000, 1'b0);
`endif

    iss(3'd2, 32'h40000000, 32'h40000000);
    store_lit("dest0", 5'd0, 32'h20000000, 1'b0);

    iss(3'd1, 32'd0, 32'd0);
    iss(3'd4, 32'h10000000, 32'd0);
    iss(3'd4, 32'h10000000, 32'd0);
    store_lit("add", 5'd1, 32'h20000000, 1'b0);

    // Negative saturation using guard bits; clrSat coincides with the set.
    iss(3'd2, 32'h80000000, 32'h7FFFFFFF);
    iss(3'd3, 32'h80000000, 32'h7FFFFFFF);
    iss(3'd3, 32'h80000000, 32'h7FFFFFFF);
    step(1'b1, 3'd5, 5'd6, 32'd0, 32'd0, 1'b0);
    chk("negsat_model", last_res, 32'h80000000);
    nop();
    step(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("negsat_data", dataW, 32'h80000000);
    chk("set_beats_clr", 32'(satFlag), 32'd1);
    step(1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("clr_after", 32'(satFlag), 32'd0);

    // Invalid opcode and unissued ops leave acc alone.
    iss(3'd1, 32'd0, 32'd0);
    iss(3'd2, 32'h40000000, 32'h40000000);
    iss(3'd6, 32'h7FFFFFFF, 32'h7FFFFFFF);
    step(1'b0, 3'd3, 5'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    step(1'b0, 3'd5, 5'd9, 32'd0, 32'd0, 1'b0);
    store_lit("hold", 5'd8, 32'h20000000, 1'b0);

    // Back-to-back stores.
    step(1'b1, 3'd5, 5'd10, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'd5, 5'd11, 32'd0, 32'd0, 1'b0);
    nop(); nop(); nop();

    // Reset one cycle after STORE issue kills the in-flight MAC and STORE.
    iss(3'd1, 32'd0, 32'd0);
    iss(3'd2, 32'h40000000, 32'h40000000);
    iss(3'd3, 32'h40000000, 32'h40000000);
    step(1'b1, 3'd5, 5'd4, 32'd0, 32'd0, 1'b0);
    do_reset();
    nop(); nop(); nop(); nop();
    store_lit("post_rst", 5'd4, 32'h00000000, 1'b0);

    nop(); nop(); nop(); nop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
